// File: rtl/gray2rgb_pkg.sv
// Shared definitions for the gray-to-RGB output path: render modes and fixed colours.
package gray2rgb_pkg;

    typedef enum logic [1:0] {
        MODE_REPL   = 2'd0,
        MODE_PSEUDO = 2'd1,
        MODE_BIN    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

endpackage

// File: rtl/sync_delay.sv
// Fixed-length shift delay for a bundle of sync/enable bits.
// Reusable by any video filter that needs its syncs aligned to an N-stage data pipeline.
module sync_delay #(
    parameter int unsigned W = 3,
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] d_o
);

    logic [W-1:0] pipe_q [N];

    // Shift the bundle one stage per clock; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned i = 1; i < N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign d_o = pipe_q[N-1];

endmodule

// File: rtl/gray_to_rgb.sv
// Gray-to-RGB renderer for the display output path, two-cycle pipeline.
// Modes: replicate, pseudo-color ramp, binary threshold. Mode and threshold are latched
// only on the vsync leading edge so a frame never mixes modes.
// Optional feature: define GRAY2RGB_PSEUDO_EN to build the pseudo-color map; otherwise
// mode 1 renders as replicate (mode_active still reports 1).
module gray_to_rgb
    import gray2rgb_pkg::*;
#(
    parameter logic [1:0] MODE_DEF = 2'd0,
    parameter logic [7:0] THR_DEF  = 8'd128,
    parameter logic       VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gray_hsync,
    input  logic        gray_vsync,
    input  logic [7:0]  gray_data,
    input  logic        gray_de,
    input  logic [1:0]  mode_cfg,
    input  logic [7:0]  thr_cfg,
    output logic        rgb_hsync,
    output logic        rgb_vsync,
    output logic [23:0] rgb_data,
    output logic        rgb_de,
    output logic [1:0]  mode_active
);

    // Colour map for one pixel; reserved mode falls through to replicate.
    function automatic logic [23:0] color_map(input logic [7:0] g,
                                              input logic [1:0] mode,
                                              input logic [7:0] thr);
`ifdef GRAY2RGB_PSEUDO_EN
        logic [7:0] ramp;
        logic [7:0] ramp_inv;
`endif
        color_map = {g, g, g};
        case (mode_e'(mode))
            MODE_BIN: color_map = (g >= thr) ? RGB_WHITE : RGB_BLACK;
`ifdef GRAY2RGB_PSEUDO_EN
            MODE_PSEUDO: begin
                // ramp tops out at 252, so 255-ramp never underflows.
                ramp     = {g[5:0], 2'b00};
                ramp_inv = 8'hFF - ramp;
                case (g[7:6])
                    2'd0:    color_map = {8'h00, ramp,  8'hFF};
                    2'd1:    color_map = {8'h00, 8'hFF, ramp_inv};
                    2'd2:    color_map = {ramp,  8'hFF, 8'h00};
                    default: color_map = {8'hFF, ramp_inv, 8'h00};
                endcase
            end
`endif
            default: color_map = {g, g, g};
        endcase
    endfunction

    logic [7:0]  g1_q;
    logic        de1_q;
    logic [23:0] rgb_d, rgb_q;
    logic [1:0]  mode_q;
    logic [7:0]  thr_q;
    logic        vs_q;
    logic        vs_lead;
    logic [2:0]  sync_out;

    assign vs_lead = (gray_vsync == VS_POL) && (vs_q != VS_POL);

    // Vsync edge detector and frame-start capture of mode/threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= ~VS_POL;
            mode_q <= MODE_DEF;
            thr_q  <= THR_DEF;
        end else begin
            vs_q <= gray_vsync;
            if (vs_lead) begin
                mode_q <= mode_cfg;
                thr_q  <= thr_cfg;
            end
        end
    end

    // Stage 1: register the incoming pixel and its enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g1_q  <= 8'h00;
            de1_q <= 1'b0;
        end else begin
            g1_q  <= gray_data;
            de1_q <= gray_de;
        end
    end

    // Stage 2 next state: blanking forces black regardless of mode.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (de1_q) begin
            rgb_d = color_map(g1_q, mode_q, thr_q);
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= RGB_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    sync_delay #(
        .W(3),
        .N(2)
    ) u_sync_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({gray_hsync, gray_vsync, gray_de}),
        .d_o  (sync_out)
    );

    assign rgb_hsync   = sync_out[2];
    assign rgb_vsync   = sync_out[1];
    assign rgb_de      = sync_out[0];
    assign rgb_data    = rgb_q;
    assign mode_active = mode_q;

endmodule

// File: tb/tb_gray_to_rgb.sv
// Directed testbench for gray_to_rgb with hand-computed expected pixels.
module tb_gray_to_rgb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gray_hsync, gray_vsync, gray_de;
    logic [7:0]  gray_data;
    logic [1:0]  mode_cfg;
    logic [7:0]  thr_cfg;
    logic        rgb_hsync, rgb_vsync, rgb_de;
    logic [23:0] rgb_data;
    logic [1:0]  mode_active;

    int n_chk  = 0;
    int n_pass = 0;

    gray_to_rgb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_hsync (gray_hsync),
        .gray_vsync (gray_vsync),
        .gray_data  (gray_data),
        .gray_de    (gray_de),
        .mode_cfg   (mode_cfg),
        .thr_cfg    (thr_cfg),
        .rgb_hsync  (rgb_hsync),
        .rgb_vsync  (rgb_vsync),
        .rgb_data   (rgb_data),
        .rgb_de     (rgb_de),
        .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one active pixel and check it at the output two cycles later.
    task automatic pix(input string tag, input logic [7:0] g, input logic [23:0] exp);
        gray_de   = 1'b1;
        gray_data = g;
        step();
        gray_de = 1'b0;
        step();
        check(tag, {8'h0, rgb_data}, {8'h0, exp});
        check({tag, "_de"}, {31'h0, rgb_de}, 32'h1);
    endtask

    // Vsync pulse with blanking; cfg changed after capture must be ignored.
    task automatic frame(input logic [1:0] m, input logic [7:0] t);
        gray_de    = 1'b0;
        mode_cfg   = m;
        thr_cfg    = t;
        gray_vsync = 1'b1;
        step();
        mode_cfg = ~m;
        thr_cfg  = ~t;
        step();
        check("vs_aligned", {31'h0, rgb_vsync}, 32'h1);
        gray_vsync = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        gray_hsync = 1'b0;
        gray_vsync = 1'b0;
        gray_de    = 1'b0;
        gray_data  = 8'h00;
        mode_cfg   = 2'd0;
        thr_cfg    = 8'h00;
        #12;
        check("rst_data", {8'h0, rgb_data}, 32'h0);
        check("rst_de", {31'h0, rgb_de}, 32'h0);
        check("rst_syncs", {30'h0, rgb_hsync, rgb_vsync}, 32'h0);
        check("rst_mode", {30'h0, mode_active}, 32'd0);
        rst_n = 1'b1;
        step();

        // Replicate after reset; check two-cycle latency and sync alignment.
        gray_de    = 1'b1;
        gray_hsync = 1'b1;
        gray_data  = 8'h5A;
        step();
        gray_de    = 1'b0;
        gray_hsync = 1'b0;
        check("lat1_de", {31'h0, rgb_de}, 32'h0);
        step();
        check("repl_5a", {8'h0, rgb_data}, 32'h5A5A5A);
        check("repl_de", {31'h0, rgb_de}, 32'h1);
        check("repl_hs", {31'h0, rgb_hsync}, 32'h1);
        check("repl_vs", {31'h0, rgb_vsync}, 32'h0);
        step();
        check("blank_after", {8'h0, rgb_data}, 32'h0);

        // Pseudo-color (replicate when the feature is not built).
        frame(2'd1, 8'h80);
        check("mode_pseudo", {30'h0, mode_active}, 32'd1);
`ifdef GRAY2RGB_PSEUDO_EN
        pix("ps_20", 8'h20, 24'h0080FF);
        pix("ps_50", 8'h50, 24'h00FFBF);
        pix("ps_a0", 8'hA0, 24'h80FF00);
        pix("ps_f0", 8'hF0, 24'hFF3F00);
        pix("ps_3f", 8'h3F, 24'h00FCFF);
        pix("ps_ff", 8'hFF, 24'hFF0300);
`else
        pix("ps_20", 8'h20, 24'h202020);
        pix("ps_a0", 8'hA0, 24'hA0A0A0);
        pix("ps_ff", 8'hFF, 24'hFFFFFF);
`endif
        // Blanking is black even in pseudo mode.
        gray_de   = 1'b0;
        gray_data = 8'hFF;
        step();
        step();
        check("ps_blank", {8'h0, rgb_data}, 32'h0);

        // Binary threshold, equality is white.
        frame(2'd2, 8'h80);
        check("mode_bin", {30'h0, mode_active}, 32'd2);
        pix("bin_7f", 8'h7F, 24'h000000);
        pix("bin_80", 8'h80, 24'hFFFFFF);
        pix("bin_ff", 8'hFF, 24'hFFFFFF);

        // Mid-frame mode change is ignored until the next leading edge.
        frame(2'd0, 8'h80);
        mode_cfg = 2'd2;
        pix("mid_40", 8'h40, 24'h404040);
        check("mid_mode", {30'h0, mode_active}, 32'd0);
        frame(2'd2, 8'h80);
        pix("new_40", 8'h40, 24'h000000);

        // Vsync held active: one capture only.
        mode_cfg   = 2'd3;
        gray_vsync = 1'b1;
        step();
        mode_cfg = 2'd1;
        for (int i = 0; i < 5; i++) step();
        check("hold_mode", {30'h0, mode_active}, 32'd3);
        gray_vsync = 1'b0;
        step();
        pix("rsvd_33", 8'h33, 24'h333333);

        // Async reset mid-line clears everything immediately.
        frame(2'd2, 8'h10);
        gray_de    = 1'b1;
        gray_hsync = 1'b1;
        gray_data  = 8'hF0;
        step();
        step();
        check("pre_rst", {8'h0, rgb_data}, 32'hFFFFFF);
        rst_n = 1'b0;
        #1;
        check("arst_data", {8'h0, rgb_data}, 32'h0);
        check("arst_de", {31'h0, rgb_de}, 32'h0);
        check("arst_hs", {31'h0, rgb_hsync}, 32'h0);
        check("arst_mode", {30'h0, mode_active}, 32'd0);
        step();
        rst_n = 1'b1;
        gray_data = 8'h21;
        step();
        gray_de = 1'b0;
        check("post_lat1", {31'h0, rgb_de}, 32'h0);
        step();
        check("post_de", {31'h0, rgb_de}, 32'h1);
        check("post_data", {8'h0, rgb_data}, 32'h212121);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
